// File: rtl/sbt_predictor.sv
// sbt_predictor: direct-mapped branch predictor with 2-bit counters, tags and targets,
// plus a one-entry pending-write stage with lookup bypass. Define SBT_RAS_EN to add a return address stack.
package sbt_pkg;
  typedef logic [31:0] virt_t;
  typedef logic [1:0]  cf_t;

  localparam cf_t CF_BRANCH = 2'd0;
  localparam cf_t CF_JUMP   = 2'd1;
  localparam cf_t CF_CALL   = 2'd2;
  localparam cf_t CF_RETURN = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       taken;
    virt_t      target;
    logic [1:0] counter;
    cf_t        cf;
  } branch_predict_t;

  typedef struct packed {
    logic       valid;
    logic       taken;
    virt_t      target;
    logic [1:0] counter;
    virt_t      pc;
    cf_t        cf;
    logic       mispredict;
  } branch_resolved_t;
endpackage

module sbt_predictor
  import sbt_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lookup_req,
  input  virt_t            lookup_pc,
  output branch_predict_t  predict,
  input  branch_resolved_t resolved
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Only the valid bits need reset; the payload arrays are plain memory.
  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_mem     [ENTRIES];
  virt_t              target_mem  [ENTRIES];
  logic [1:0]         counter_mem [ENTRIES];
  cf_t                cf_mem      [ENTRIES];

  logic       pend_valid_reg;
  virt_t      pend_pc_reg;
  logic       pend_taken_reg;
  virt_t      pend_target_reg;
  logic [1:0] pend_counter_reg;
  cf_t        pend_cf_reg;

  branch_predict_t predict_reg;
  branch_predict_t predict_next;

  logic [IDX_W-1:0] pend_idx;
  logic [TAG_W-1:0] pend_tag;
  logic             pend_hit;
  logic             wr_en;
  logic [1:0]       wr_counter;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             byp;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  virt_t            e_target;
  logic [1:0]       e_counter;
  cf_t              e_cf;
  logic             lk_hit;
  virt_t            sel_target;

  logic unused_bits;
  assign unused_bits = &{1'b0, lookup_pc[1:0], pend_pc_reg[1:0], resolved.mispredict};

  // Pending update capture: every resolved branch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg   <= 1'b0;
      pend_pc_reg      <= '0;
      pend_taken_reg   <= 1'b0;
      pend_target_reg  <= '0;
      pend_counter_reg <= '0;
      pend_cf_reg      <= CF_BRANCH;
    end else begin
      pend_valid_reg <= resolved.valid;
      if (resolved.valid) begin
        pend_pc_reg      <= resolved.pc;
        pend_taken_reg   <= resolved.taken;
        pend_target_reg  <= resolved.target;
        pend_counter_reg <= resolved.counter;
        pend_cf_reg      <= resolved.cf;
      end
    end
  end

  assign pend_idx = pend_pc_reg[IDX_W+1:2];
  assign pend_tag = pend_pc_reg[31:IDX_W+2];
  assign pend_hit = valid_reg[pend_idx] && (tag_mem[pend_idx] == pend_tag);
  assign wr_en    = pend_valid_reg && (pend_hit || pend_taken_reg);

  // Training starts from the counter the branch unit saw, not the current entry.
  always_comb begin
    wr_counter = 2'b10;
    if (pend_hit) begin
      if (pend_taken_reg)
        wr_counter = (pend_counter_reg == 2'b11) ? 2'b11 : pend_counter_reg + 2'd1;
      else
        wr_counter = (pend_counter_reg == 2'b00) ? 2'b00 : pend_counter_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[pend_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[pend_idx]     <= pend_tag;
      target_mem[pend_idx]  <= pend_target_reg;
      counter_mem[pend_idx] <= wr_counter;
      cf_mem[pend_idx]      <= pend_cf_reg;
    end
  end

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign byp    = wr_en && (pend_idx == lk_idx);

  // A write landing on the same edge is forwarded so the lookup sees post-write contents.
  always_comb begin
    e_valid   = valid_reg[lk_idx];
    e_tag     = tag_mem[lk_idx];
    e_target  = target_mem[lk_idx];
    e_counter = counter_mem[lk_idx];
    e_cf      = cf_mem[lk_idx];
    if (byp) begin
      e_valid   = 1'b1;
      e_tag     = pend_tag;
      e_target  = pend_target_reg;
      e_counter = wr_counter;
      e_cf      = pend_cf_reg;
    end
  end

  assign lk_hit = lookup_req && e_valid && (e_tag == lk_tag);

`ifdef SBT_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);

  logic [RAS_W-1:0] ras_ptr_reg;
  logic [RAS_W-1:0] ras_top_idx;
  virt_t            ras_mem [RAS_DEPTH];
  logic             ras_push;
  logic             ras_pop;

  assign ras_top_idx = ras_ptr_reg - RAS_W'(1);
  assign ras_push    = lk_hit && !flush && (e_cf == CF_CALL);
  assign ras_pop     = lk_hit && !flush && (e_cf == CF_RETURN);
  assign sel_target  = (e_cf == CF_RETURN) ? ras_mem[ras_top_idx] : e_target;

  // Pointer wraps on both overflow and underflow; storage is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr_reg <= '0;
    end else if (ras_push) begin
      ras_ptr_reg <= ras_ptr_reg + RAS_W'(1);
    end else if (ras_pop) begin
      ras_ptr_reg <= ras_top_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr_reg] <= lookup_pc + 32'd8;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign sel_target = e_target;
`endif

  always_comb begin
    predict_next = '0;
    if (lk_hit && !flush) begin
      predict_next.valid   = 1'b1;
      predict_next.taken   = e_counter[1] || (e_cf != CF_BRANCH);
      predict_next.target  = sel_target;
      predict_next.counter = e_counter;
      predict_next.cf      = e_cf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_reg <= '0;
    end else begin
      predict_reg <= predict_next;
    end
  end

  assign predict = predict_reg;

endmodule

// File: tb/tb_sbt_predictor.sv
// Scoreboard bench for sbt_predictor: driver runs a table-level reference model and queues
// expected predictions; a monitor compares them against the registered predict output.
module tb_sbt_predictor;
  import sbt_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             lookup_req = 1'b0;
  virt_t            lookup_pc = '0;
  branch_predict_t  predict;
  branch_resolved_t resolved = '0;

  always #5 clk = ~clk;

  sbt_predictor #(.ENTRIES(64), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .lookup_req(lookup_req),
    .lookup_pc(lookup_pc), .predict(predict), .resolved(resolved)
  );

  int total = 0;
  int bad = 0;
  bit active = 1'b0;
  branch_predict_t exp_q[$];
  branch_predict_t mon_e;

  // Reference model: one record per table slot plus the single pending update.
  bit    mv  [64];
  int    mt  [64];
  virt_t mtg [64];
  int    mc  [64];
  cf_t   mcf [64];
  bit    pv;
  virt_t ppc, ptg;
  bit    ptk;
  int    pcnt;
  cf_t   pcf;
  virt_t m_ras [8];
  int    m_sp;

  function automatic void model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    pv = 1'b0;
    m_sp = 0;
  endfunction

  function automatic void model_step();
    int i;
    branch_predict_t e;
    if (pv) begin
      i = int'(ppc[7:2]);
      if (mv[i] && mt[i] == int'(ppc[31:8])) begin
        mc[i]  = ptk ? ((pcnt < 3) ? pcnt + 1 : 3) : ((pcnt > 0) ? pcnt - 1 : 0);
        mtg[i] = ptg;
        mcf[i] = pcf;
      end else if (ptk) begin
        mv[i] = 1'b1; mt[i] = int'(ppc[31:8]); mtg[i] = ptg; mcf[i] = pcf; mc[i] = 2;
      end
    end
    e = '0;
    if (lookup_req && !flush) begin
      i = int'(lookup_pc[7:2]);
      if (mv[i] && mt[i] == int'(lookup_pc[31:8])) begin
        e.valid   = 1'b1;
        e.counter = 2'(mc[i]);
        e.cf      = mcf[i];
        e.target  = mtg[i];
        e.taken   = (mc[i] >= 2) || (mcf[i] != CF_BRANCH);
`ifdef SBT_RAS_EN
        if (mcf[i] == CF_CALL) begin
          m_ras[m_sp] = lookup_pc + 32'd8;
          m_sp = (m_sp + 1) % 8;
        end else if (mcf[i] == CF_RETURN) begin
          m_sp = (m_sp + 7) % 8;
          e.target = m_ras[m_sp];
        end
`endif
      end
    end
    exp_q.push_back(e);
    pv = resolved.valid;
    if (resolved.valid) begin
      ppc = resolved.pc; ptk = resolved.taken; ptg = resolved.target;
      pcnt = int'(resolved.counter); pcf = resolved.cf;
    end
  endfunction

  task automatic drive(input bit lr, input virt_t lpc, input bit fl, input bit rv,
                       input virt_t rpc, input bit rtk, input virt_t rtg,
                       input logic [1:0] rc, input cf_t rcf);
    @(negedge clk);
    lookup_req = lr; lookup_pc = lpc; flush = fl;
    resolved.valid = rv; resolved.pc = rpc; resolved.taken = rtk;
    resolved.target = rtg; resolved.counter = rc; resolved.cf = rcf;
    resolved.mispredict = 1'($urandom);
    model_step();
    active = 1'b1;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, 0, '0, 2'b00, CF_BRANCH);
  endtask

  task automatic look(input virt_t pc);
    drive(1, pc, 0, 0, '0, 0, '0, 2'b00, CF_BRANCH);
  endtask

  task automatic upd(input virt_t pc, input bit tk, input virt_t tg, input logic [1:0] c, input cf_t cf);
    drive(0, '0, 0, 1, pc, tk, tg, c, cf);
  endtask

  // Asserts reset mid-cycle (after the monitor has sampled) and checks predict clears at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    active = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (predict !== '0) begin
      bad++;
      $display("FAIL reset_predict: got %h required 0", predict);
    end
    exp_q.delete();
    model_reset();
    lookup_req = 1'b0; flush = 1'b0; resolved.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL predict_queue: got output with no expected entry, required one queued");
        end else begin
          mon_e = exp_q.pop_front();
          if (predict !== mon_e) begin
            bad++;
            $display("FAIL predict: got v=%0b tk=%0b tg=%h c=%0d cf=%0d required v=%0b tk=%0b tg=%h c=%0d cf=%0d",
                     predict.valid, predict.taken, predict.target, predict.counter, predict.cf,
                     mon_e.valid, mon_e.taken, mon_e.target, mon_e.counter, mon_e.cf);
          end
        end
      end
    end
  end

  function automatic virt_t rand_pc();
    virt_t t, ix;
    t  = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h8001_0000;
    ix = virt_t'($urandom_range(0, 7));
    return t | (ix << 2);
  endfunction

  localparam virt_t PA = 32'h8000_0040;
  localparam virt_t PB = 32'h8000_0080;
  localparam virt_t PC = 32'h8001_0040;

  initial begin
    model_reset();
    do_reset();
    look(PA);
    upd(PA, 1, 32'h8000_0100, 2'b00, CF_BRANCH);
    idle();
    look(PA);
    upd(PA, 0, 32'h8000_0100, 2'b10, CF_BRANCH);
    upd(PA, 0, 32'h8000_0100, 2'b01, CF_BRANCH);
    upd(PA, 0, 32'h8000_0100, 2'b00, CF_BRANCH);
    idle();
    look(PA);
    upd(PA, 1, 32'h8000_0100, 2'b11, CF_BRANCH);
    idle();
    look(PA);
    drive(1, PB, 0, 1, PB, 1, 32'h8000_0300, 2'b01, CF_JUMP);
    look(PB);
    upd(PA, 1, 32'h8000_0100, 2'b01, CF_BRANCH);
    upd(PC, 1, 32'h8000_0500, 2'b01, CF_BRANCH);
    idle();
    look(PA);
    look(PC);
    drive(1, PC, 1, 0, '0, 0, '0, 2'b00, CF_BRANCH);
    look(PC);
`ifdef SBT_RAS_EN
    upd(32'h8000_0200, 1, 32'h8000_0600, 2'b00, CF_CALL);
    upd(32'h8000_0300, 1, 32'h8000_0700, 2'b00, CF_RETURN);
    idle();
    look(32'h8000_0200);
    look(32'h8000_0300);
    for (int k = 0; k < 9; k++) upd(32'h8000_0400 + 32'(4 * k), 1, 32'h8000_0800, 2'b00, CF_CALL);
    idle();
    for (int k = 0; k < 9; k++) look(32'h8000_0400 + 32'(4 * k));
    for (int k = 0; k < 9; k++) look(32'h8000_0300);
`endif
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 9) == 0,
            1'($urandom), rand_pc(), $urandom_range(0, 2) != 0,
            32'h8000_0000 | virt_t'($urandom_range(0, 1023) << 2),
            2'($urandom), cf_t'($urandom));
    end
    // Pending update killed by reset: the table must come back empty.
    drive(1, PA, 0, 1, PB, 1, 32'h8000_0900, 2'b10, CF_BRANCH);
    do_reset();
    look(PB);
    look(PA);
    idle();
    @(posedge clk);
    #2;
    active = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d leftover required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbt_predictor.md
# sbt_predictor

Branch target/direction predictor feeding fetch and trained by resolved branches.
- Holds a direct-mapped table of saturating 2-bit counters, tags and targets.
- Answers one fetch lookup per cycle with a registered `branch_predict_t`.
- Absorbs one `branch_resolved_t` per cycle from the branch execution unit through a one-entry pending-write stage with lookup bypass.
- Optional return address stack (RAS) supplies targets for returns.

## Interface
Parameters:
- `ENTRIES`, 64: table entries, power of two; `IDX_W = $clog2(ENTRIES)`.
- `RAS_DEPTH`, 8: RAS entries, power of two; used only with `SBT_RAS_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline redirect; kills the in-flight prediction.
- `lookup_req`  in  1  fetch lookup valid this cycle.
- `lookup_pc`  in  32  fetch virtual address (`virt_t`), word aligned.
- `predict`  out  `branch_predict_t`  fields `valid`, `taken`, `target`, `counter`, `cf`; registered.
- `resolved`  in  `branch_resolved_t`  fields `valid`, `taken`, `target`, `counter`, `pc`, `cf`, `mispredict`.

## Operation
- Index is `pc[IDX_W+1:2]`; tag is `pc[31:IDX_W+2]`.
- Entry contents: `valid`, `tag`, `target[31:0]`, `counter[1:0]`, `cf`.
- Lookup, when `lookup_req` is high:
  - Read entry at index. Hit = `valid & tag match`.
  - `predict.valid` = hit.
  - `predict.counter` and `predict.cf` come from the entry.
  - `predict.target` comes from the entry, except `cf == CF_RETURN` with the RAS enabled.
  - `predict.taken` = hit & (`counter[1]` | `cf` ∈ {CF_JUMP, CF_CALL, CF_RETURN}).
  - Miss: `predict` is all zero.
- Update capture: when `resolved.valid`, latch `{pc, taken, target, counter, cf}` into the pending register. Always accepted; no backpressure.
- Update write (cycle after capture), on the pending index:
  - Tag hit: new counter = `resolved.counter` +1 if taken, −1 if not, saturating at 2'b11 and 2'b00. Rewrite target and cf.
  - Tag miss, taken: allocate. `valid`=1, new tag, target, cf, counter=2'b10. Evicts any occupant.
  - Tag miss, not taken: no write.
- Bypass: if the pending write index equals the lookup index on the same edge, the lookup sees post-write entry contents.
- `flush`: clears the `predict` register on that edge, even when `lookup_req` is high. Never discards the pending update.

## Timing
- Lookup latency is 1: `lookup_pc` sampled at edge N, `predict` valid after edge N.
- `predict` holds zero in any cycle following an edge with `!lookup_req` or `flush`.
- Update latency is 2: `resolved` sampled at edge N, table written at edge N+1. A lookup sampled at edge N+1 to the same index sees the new value through bypass. A lookup sampled at edge N sees the old value.
- Back-to-back updates: one per cycle, pipelined. Two consecutive updates to the same index apply in order; the second sees the first's write.
- Reset (async assert):
  - All entry `valid` bits cleared.
  - `predict` = 0.
  - Pending valid = 0.
  - RAS pointer = 0.
  - Deassertion is synchronous to `clk`.
- Reset mid-update: the pending write is lost; the table ends empty.

## Configuration
- `SBT_RAS_EN` defined: RAS of `RAS_DEPTH` × 32 bits, enabled as follows.
  - Lookup hit with `cf == CF_CALL` pushes `lookup_pc + 8`.
  - Lookup hit with `cf == CF_RETURN` sets `predict.target` = RAS top and pops.
  - Push/pop happen at the lookup edge, speculatively, and are suppressed by `flush`.
  - Overflow wraps and overwrites the oldest entry.
  - Underflow wraps the pointer and returns a stale value.
- `SBT_RAS_EN` undefined: no RAS storage. Returns use the stored table target.

## Test plan
- Reset, then lookup `0x8000_0040` -> `predict` = 0 next cycle.
- Allocate and hit: resolved `{pc=0x8000_0040, taken=1, target=0x8000_0100, cf=CF_BRANCH}`, then lookup same pc two cycles later -> `valid=1, taken=1, target=0x8000_0100, counter=2'b10`.
- Saturation: three updates at `0x8000_0040` with taken=0 and counter 10→01→00→00 -> lookup shows `taken=0, counter=2'b00`. Fourth update with `counter=2'b11, taken=1` -> counter stays 2'b11.
- Bypass: resolved for `0x8000_0080` at edge N, lookup `0x8000_0080` at edge N+1 -> hit.
- Same-edge lookup: lookup `0x8000_0080` at edge N -> miss.
- Alias and flush: update `0x8000_0040` then `0x8001_0040` (same index with ENTRIES=64) -> first pc now misses. `flush` together with `lookup_req` -> `predict` = 0.
- RAS (`SBT_RAS_EN`): call entry at `0x8000_0200` looked up, then return entry looked up -> `predict.target = 0x8000_0208`. Nine calls with RAS_DEPTH=8, then nine returns -> first eight targets correct in LIFO order.
